// File: rtl/nn_host_bridge_if.sv
// Host-side memory-mapped bus of the inference bridge: req/ack handshake, 12-bit address, byte data.
// Completion is a one-cycle ack pulse; the master holds req until it sees ack.
interface nn_host_bridge_if;
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/nn_host_bridge.sv
// Host/engine bridge for the inference core and its shared RAM; optional irq output under NN_HOST_IRQ_EN.
// Acks one cycle after an accepted request; host RAM accesses stall (no ack) while the engine owns the RAM.
module nn_host_bridge #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int START_GUARD    = 2
) (
    input  logic              clk,
    input  logic              reset,
    nn_host_bridge_if.slave   host,
    output logic              nn_run_inference,
    input  logic              nn_ready,
    input  logic [ADDR_W-1:0] nn_RAM_address,
    input  logic [7:0]        nn_RAM_wd,
    input  logic              nn_RAM_we,
    output logic [7:0]        nn_RAM_rd,
    output logic [ADDR_W-1:0] RAM_address,
    output logic [7:0]        RAM_wd,
    output logic              RAM_we,
    input  logic [7:0]        RAM_rd
`ifdef NN_HOST_IRQ_EN
    ,
    output logic              irq
`endif
);

    typedef enum logic [2:0] {IDLE, START, GUARD, RUN, DONE, ABORT} state_t;

    localparam logic [15:0] GUARD_END   = 16'(START_GUARD);
    localparam logic [15:0] TIMEOUT_END = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] cycles;
    logic [15:0] cycles_inc;
    logic [7:0]  result;
    logic        done;
    logic        timeout;
    logic        cyc_hi;
    logic        irq_en;
    logic        busy;
    logic        eng_owns;
    logic        acc;
    logic        reg_acc;
    logic        ram_acc;
    logic        ctrl_wr;
    logic        stat_wr;
    logic [7:0]  reg_rdata;
    logic        unused_addr;

    assign busy       = (state != IDLE);
    assign eng_owns   = (state == START) || (state == GUARD) || (state == RUN);
    // A request still high in the ack cycle is the tail of the access just completed.
    assign acc        = host.req && !host.ack;
    assign reg_acc    = acc && host.addr[11];
    assign ram_acc    = acc && !host.addr[11] && !eng_owns;
    assign ctrl_wr    = reg_acc && host.we && (host.addr[1:0] == 2'd0);
    assign stat_wr    = reg_acc && host.we && (host.addr[1:0] == 2'd1);
    assign cycles_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
    assign nn_RAM_rd  = RAM_rd;
    assign unused_addr = ^host.addr[10:2];

    always_comb begin
        RAM_address = '0;
        RAM_wd      = 8'h00;
        RAM_we      = 1'b0;
        if (eng_owns) begin
            RAM_address = nn_RAM_address;
            RAM_wd      = nn_RAM_wd;
            RAM_we      = nn_RAM_we;
        end else if (ram_acc) begin
            RAM_address = host.addr[ADDR_W-1:0];
            RAM_wd      = host.wdata;
            RAM_we      = host.we;
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (host.addr[1:0])
            2'd0:    reg_rdata = {6'b0, irq_en, busy};
            2'd1:    reg_rdata = {5'b0, timeout, done, busy};
            2'd2:    reg_rdata = result;
            default: reg_rdata = cyc_hi ? cycles[15:8] : cycles[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            nn_run_inference <= 1'b0;
            cycles           <= 16'h0000;
            result           <= 8'h00;
            done             <= 1'b0;
            timeout          <= 1'b0;
            cyc_hi           <= 1'b0;
            host.ack         <= 1'b0;
            host.rdata       <= 8'h00;
        end else begin
            nn_run_inference <= 1'b0;
            host.ack         <= reg_acc || ram_acc;
            if (reg_acc) begin
                host.rdata <= reg_rdata;
            end else if (ram_acc) begin
                host.rdata <= RAM_rd;
            end
            if (ctrl_wr) begin
                cyc_hi <= host.wdata[0];
            end
            if (stat_wr) begin
                if (host.wdata[1]) done    <= 1'b0;
                if (host.wdata[2]) timeout <= 1'b0;
            end
            if (((state == GUARD) || (state == RUN)) && nn_RAM_we) begin
                result <= nn_RAM_wd;
            end
            // State actions come after the W1C above so a same-cycle set wins.
            case (state)
                IDLE: begin
                    if (ctrl_wr && host.wdata[0]) begin
                        state            <= START;
                        nn_run_inference <= 1'b1;
                    end
                end
                START: begin
                    done    <= 1'b0;
                    timeout <= 1'b0;
                    cycles  <= 16'h0000;
                    state   <= GUARD;
                end
                GUARD: begin
                    cycles <= cycles_inc;
                    if (cycles_inc >= GUARD_END) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    cycles <= cycles_inc;
                    if (nn_ready) begin
                        state <= DONE;
                    end else if (cycles_inc >= TIMEOUT_END) begin
                        state <= ABORT;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                ABORT: begin
                    timeout <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NN_HOST_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en <= host.wdata[1];
        end
    end

    assign irq = irq_en && (done || timeout);
`else
    assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_nn_host_bridge.sv
// Directed bench for nn_host_bridge with an external RAM model, an inline engine model and a read-data scoreboard.
module tb_nn_host_bridge;

    localparam int          G      = 2;
    localparam logic [11:0] CTRL   = 12'h800;
    localparam logic [11:0] STATUS = 12'h801;
    localparam logic [11:0] RESULT = 12'h802;
    localparam logic [11:0] CYCLES = 12'h803;
`ifdef NN_HOST_IRQ_EN
    localparam logic [7:0]  CTRL_B1 = 8'h02;
`else
    localparam logic [7:0]  CTRL_B1 = 8'h00;
`endif

    logic       clk;
    logic       reset;
    logic       nn_run_inference;
    logic       nn_ready;
    logic [9:0] nn_RAM_address;
    logic [7:0] nn_RAM_wd;
    logic       nn_RAM_we;
    logic [7:0] nn_RAM_rd;
    logic [9:0] RAM_address;
    logic [7:0] RAM_wd;
    logic       RAM_we;
    logic [7:0] RAM_rd;
`ifdef NN_HOST_IRQ_EN
    logic       irq;
`endif

    nn_host_bridge_if host ();

    nn_host_bridge #(
        .ADDR_W         (10),
        .TIMEOUT_CYCLES (100),
        .START_GUARD    (G)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .host             (host),
        .nn_run_inference (nn_run_inference),
        .nn_ready         (nn_ready),
        .nn_RAM_address   (nn_RAM_address),
        .nn_RAM_wd        (nn_RAM_wd),
        .nn_RAM_we        (nn_RAM_we),
        .nn_RAM_rd        (nn_RAM_rd),
        .RAM_address      (RAM_address),
        .RAM_wd           (RAM_wd),
        .RAM_we           (RAM_we),
        .RAM_rd           (RAM_rd)
`ifdef NN_HOST_IRQ_EN
        ,
        .irq              (irq)
`endif
    );

    logic [7:0] mem [0:1023];
    assign RAM_rd = mem[RAM_address];
    always @(posedge clk) if (RAM_we) mem[RAM_address] <= RAM_wd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int p0, ready_cyc, ack_cyc;
    logic [7:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (nn_run_inference) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns with the host idle for one cycle, so back-to-back calls respect the handshake.
    task automatic host_access(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                               output logic [7:0] rd, output int lat, output logic acked);
        host.req   = 1'b1;
        host.we    = we;
        host.addr  = addr;
        host.wdata = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!host.ack && lat < 300);
        acked = host.ack;
        rd    = host.rdata;
        host.req = 1'b0;
        host.we  = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_write(input logic [11:0] addr, input logic [7:0] v, input string tag);
        logic [7:0] rd;
        int lat;
        logic acked;
        host_access(1'b1, addr, v, rd, lat, acked);
        check({tag, "_lat"}, 16'(lat), 16'd1);
    endtask

    task automatic host_read(input logic [11:0] addr, input logic [7:0] expv, input string tag,
                             input logic chk_lat);
        logic [7:0] rd;
        logic [7:0] e;
        int lat;
        logic acked;
        sb.push_back(expv);
        host_access(1'b0, addr, 8'h00, rd, lat, acked);
        check({tag, "_ack"}, 16'(acked), 16'd1);
        if (chk_lat) check({tag, "_lat"}, 16'(lat), 16'd1);
        e = sb.pop_front();
        check(tag, 16'(rd), 16'(e));
    endtask

    initial begin
        reset = 1'b1;
        host.req = 1'b0; host.we = 1'b0; host.addr = 12'h000; host.wdata = 8'h00;
        nn_ready = 1'b1; nn_RAM_address = 10'h000; nn_RAM_wd = 8'h00; nn_RAM_we = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 16'(host.ack), 16'd0);
        check("rst_rdata", 16'(host.rdata), 16'd0);
        check("rst_pulse", 16'(nn_run_inference), 16'd0);
        check("rst_ram_we", 16'(RAM_we), 16'd0);
        reset = 1'b0;
        @(negedge clk);
        host_read(STATUS, 8'h00, "rst_status", 1'b1);
        host_read(RESULT, 8'h00, "rst_result", 1'b1);
        host_read(CYCLES, 8'h00, "rst_cycles", 1'b1);

        // Host RAM round trip
        host_write(12'h005, 8'h3A, "ram_wr");
        host_read(12'h005, 8'h3A, "ram_rd", 1'b1);

        // CTRL bit1 exists only with the irq feature
        host_write(CTRL, 8'h02, "ctrl_b1_wr");
        host_read(CTRL, CTRL_B1, "ctrl_b1_rd", 1'b1);
        host_write(CTRL, 8'h00, "ctrl_clr");

        // Normal run: ready 40 cycles after the pulse, stalled host read during the run
        p0 = pulse_cnt;
        host_write(CTRL, 8'h01, "start1");
        fork
            begin
                nn_ready = 1'b0;
                for (int k = 2; k <= 40; k++) begin
                    @(negedge clk);
                    nn_RAM_we = 1'b0;
                    if (k == 10) begin
                        nn_RAM_address = 10'h3FE; nn_RAM_wd = 8'h05; nn_RAM_we = 1'b1;
                    end
                    if (k == 20) begin
                        nn_RAM_address = 10'h3FF; nn_RAM_wd = 8'h07; nn_RAM_we = 1'b1;
                    end
                end
                nn_RAM_we = 1'b0;
                nn_ready  = 1'b1;
                ready_cyc = cyc;
            end
            begin
                repeat (4) @(negedge clk);
                host_read(12'h3FF, 8'h07, "stall_rd", 1'b0);
                ack_cyc = cyc;
            end
        join
        check("stall_ack_after_done", 16'(ack_cyc > ready_cyc), 16'd1);
        check("run1_pulses", 16'(pulse_cnt - p0), 16'd1);
        host_read(STATUS, 8'h02, "run1_status", 1'b1);
        host_read(RESULT, 8'h07, "run1_result", 1'b1);
        host_read(12'h3FE, 8'h05, "run1_eng_wr", 1'b1);
        host_write(CTRL, 8'h00, "cyc_lo_sel");
        host_read(CYCLES, 8'd40, "run1_cycles", 1'b1);

        // Timeout run with a start written while busy
        host_write(STATUS, 8'h02, "w1c_done");
        host_read(STATUS, 8'h00, "status_clr", 1'b1);
        nn_ready = 1'b0;
        p0 = pulse_cnt;
        host_write(CTRL, 8'h01, "start2");
        repeat (10) @(negedge clk);
        host_read(CTRL, 8'h01, "ctrl_busy", 1'b1);
        host_write(CTRL, 8'h01, "start_busy");
        repeat (120) @(negedge clk);
        host_read(STATUS, 8'h04, "abort_status", 1'b1);
        check("run2_pulses", 16'(pulse_cnt - p0), 16'd1);
        host_write(CTRL, 8'h00, "cyc_lo_sel2");
        host_read(CYCLES, 8'd100, "abort_cycles", 1'b1);
        host_write(STATUS, 8'h04, "w1c_timeout");
        host_read(STATUS, 8'h00, "timeout_clr", 1'b1);

        // Engine already ready at the end of the guard window
        nn_ready = 1'b1;
        host_write(CTRL, 8'h01, "start3");
        repeat (8) @(negedge clk);
        host_read(STATUS, 8'h02, "early_status", 1'b1);
        host_write(CTRL, 8'h00, "cyc_lo_sel3");
        host_read(CYCLES, 8'(G + 1), "early_cycles", 1'b1);
        host_write(STATUS, 8'h02, "w1c_done3");

        // Reset in the tenth RUN cycle while the engine is writing
        nn_ready = 1'b0;
        host_write(CTRL, 8'h01, "start4");
        repeat (11) @(negedge clk);
        nn_RAM_address = 10'h123; nn_RAM_wd = 8'hEE; nn_RAM_we = 1'b1;
        #1;
        check("eng_owns_we", 16'(RAM_we), 16'd1);
        reset = 1'b1;
        #1;
        check("midrst_ram_we", 16'(RAM_we), 16'd0);
        check("midrst_ram_addr", 16'(RAM_address), 16'd0);
        check("midrst_pulse", 16'(nn_run_inference), 16'd0);
        check("midrst_ack", 16'(host.ack), 16'd0);
        check("midrst_rdata", 16'(host.rdata), 16'd0);
        @(negedge clk);
        reset = 1'b0; nn_RAM_we = 1'b0; nn_ready = 1'b1;
        @(negedge clk);
        host_read(STATUS, 8'h00, "post_rst_status", 1'b1);
        host_write(12'h010, 8'h5C, "post_rst_wr");
        host_read(12'h010, 8'h5C, "post_rst_rd", 1'b1);

`ifdef NN_HOST_IRQ_EN
        check("irq_idle", 16'(irq), 16'd0);
        host_write(CTRL, 8'h03, "irq_start");
        repeat (8) @(negedge clk);
        check("irq_set", 16'(irq), 16'd1);
        host_write(STATUS, 8'h02, "irq_w1c");
        check("irq_clr", 16'(irq), 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
